seg_decoder: RTL

SEG_DECODER -- requirements
Module: seg_decoder

---
 rtl/seg_pkg.sv | 38 +++
 rtl/seg_digit_lut.sv | 29 ++
 rtl/seg_decoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the two-digit seven-segment decoder.
// Segment codes are written a..g from MSB to LSB (bit 6 = a, bit 0 = g).
package seg_pkg;

`ifdef SEG_DEBOUNCE_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_STABLE  = 2'd2,
    ST_DECODE  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DECODE  = 2'd3
  } state_e;
`endif

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1110011;

  // A blank tens digit means zero; only "1" may be lit.
  localparam logic [6:0] TENS_0 = 7'b0000000;
  localparam logic [6:0] TENS_1 = 7'b0110000;

  localparam logic [4:0] MAX_VALUE = 5'd15;
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/seg_digit_lut.sv
// Combinational seven-segment code to decimal digit lookup.
// Codes outside SEG_0..SEG_9 report legal_o=0 and digit_o=0.
module seg_digit_lut
  import seg_pkg::*;
(
  input  logic [6:0] code_i,
  output logic       legal_o,
  output logic [3:0] digit_o
);

  always_comb begin
    legal_o = 1'b1;
    digit_o = 4'd0;
    case (code_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_decoder.sv
// Captures a two-digit seven-segment frame and decodes it to a 4-bit value with valid/err pulses.
// Optional input debounce (STABLE state + counter) is compiled in with SEG_DEBOUNCE_EN.
module seg_decoder
  import seg_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] dse,
  input  logic [6:0] dsd,
  input  logic       ready,
  output logic       busy,
  output logic [3:0] s,
  output logic       valid,
  output logic       err
);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 15) begin : g_bad_deb_cycles
    $error("DEB_CYCLES must be in 1..15");
  end

  state_e     state_q, state_d;
  logic [6:0] dse_q, dse_d;
  logic [6:0] dsd_q, dsd_d;
  logic [3:0] s_q, s_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic       t_legal, u_legal;
  logic [3:0] t_digit, u_digit;
  logic       tens_one, tens_ok;
  logic [4:0] value;
  logic       frame_ok;

  seg_digit_lut u_tens_lut (
    .code_i  (dse_q),
    .legal_o (t_legal),
    .digit_o (t_digit)
  );

  seg_digit_lut u_units_lut (
    .code_i  (dsd_q),
    .legal_o (u_legal),
    .digit_o (u_digit)
  );

  // The tens LUT only recognises lit digits, so a blank tens position is handled here.
  assign tens_one = t_legal && (t_digit == 4'd1);
  assign tens_ok  = (dse_q == TENS_0) || tens_one;
  assign value    = (tens_one ? 5'd10 : 5'd0) + {1'b0, u_digit};
  assign frame_ok = tens_ok && u_legal && (value <= MAX_VALUE);

`ifdef SEG_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEB_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    dse_d   = dse_q;
    dsd_d   = dsd_q;
    s_d     = s_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef SEG_DEBOUNCE_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          dse_d   = dse;
          dsd_d   = dsd;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
`ifdef SEG_DEBOUNCE_EN
        cnt_d   = '0;
        state_d = ST_STABLE;
`else
        state_d = ST_DECODE;
`endif
      end
`ifdef SEG_DEBOUNCE_EN
      ST_STABLE: begin
        if (dse == dse_q && dsd == dsd_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == DEB_LIMIT) begin
            state_d = ST_DECODE;
          end
        end else begin
          dse_d = dse;
          dsd_d = dsd;
          cnt_d = '0;
        end
      end
`endif
      ST_DECODE: begin
        if (frame_ok) begin
          s_d     = value[3:0];
          valid_d = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dse_q   <= '0;
      dsd_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEG_DEBOUNCE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dse_q   <= dse_d;
      dsd_q   <= dsd_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef SEG_DEBOUNCE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign s     = s_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule
